// File: rtl/rect_wave_if.sv
// Control, configuration and waveform-output bundle for rect_wave_gen.
interface rect_wave_if #(
   parameter int unsigned AMP_W = 12,
   parameter int unsigned CNT_W = 16
) ();
   logic             start;
   logic             stop;
   logic [AMP_W-1:0] amp;
   logic [AMP_W-1:0] rise_step;
   logic [AMP_W-1:0] fall_step;
   logic [CNT_W-1:0] td;
   logic [CNT_W-1:0] tr;
   logic [CNT_W-1:0] th;
   logic [CNT_W-1:0] tf;
   logic [CNT_W-1:0] tl;
   logic [AMP_W-1:0] level;
   logic             busy;
   logic [2:0]       phase;
   logic             period_tick;

   modport master (
      output start, stop, amp, rise_step, fall_step, td, tr, th, tf, tl,
      input  level, busy, phase, period_tick
   );

   modport slave (
      input  start, stop, amp, rise_step, fall_step, td, tr, th, tf, tl,
      output level, busy, phase, period_tick
   );
endinterface

// File: rtl/rect_wave_gen.sv
// Trapezoidal/rectangular waveform sequencer: delay, then repeating
// rise/high/fall/low periods with ramped level codes for a DAC.
module rect_wave_gen #(
   parameter int unsigned AMP_W = 12,
   parameter int unsigned CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   rect_wave_if.slave  bus
);

   localparam int unsigned SUM_W = CNT_W + 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DELAY = 3'd1,
      S_RISE  = 3'd2,
      S_HIGH  = 3'd3,
      S_FALL  = 3'd4,
      S_LOW   = 3'd5
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [AMP_W-1:0] r_level;
   logic             r_busy;
   logic             r_tick;
   logic             r_stop;
   logic [AMP_W-1:0] r_amp;
   logic [AMP_W-1:0] r_rise;
   logic [AMP_W-1:0] r_fall;
   logic [CNT_W-1:0] r_tr;
   logic [CNT_W-1:0] r_th;
   logic [CNT_W-1:0] r_tf;
   logic [CNT_W-1:0] r_tl;

   logic             w_idle;
   logic [SUM_W-1:0] w_sum;
   logic             w_accept;
   logic [AMP_W-1:0] w_amp;
   logic [AMP_W-1:0] w_rise;
   logic [AMP_W-1:0] w_fall;
   logic [CNT_W-1:0] w_tr;
   logic [CNT_W-1:0] w_th;
   logic [CNT_W-1:0] w_tf;
   logic [CNT_W-1:0] w_tl;
   logic [2:0]       w_base;
   state_t           w_pick;
   logic [CNT_W-1:0] w_pick_dur;
   state_t           w_nxt;
   logic [CNT_W-1:0] w_nxt_cnt;
   logic             w_last;
   logic             w_tick_nxt;
   logic [AMP_W:0]   w_lvl_up;
   logic [AMP_W-1:0] w_lvl_nxt;
   logic             w_stop_nxt;

   // Start acceptance; configuration comes straight from the inputs while idle.
   assign w_idle   = (r_state == S_IDLE);
   assign w_sum    = SUM_W'(bus.tr) + SUM_W'(bus.th) + SUM_W'(bus.tf) + SUM_W'(bus.tl);
   assign w_accept = w_idle && bus.start && (w_sum != '0);
   assign w_amp    = w_idle ? bus.amp       : r_amp;
   assign w_rise   = w_idle ? bus.rise_step : r_rise;
   assign w_fall   = w_idle ? bus.fall_step : r_fall;
   assign w_tr     = w_idle ? bus.tr        : r_tr;
   assign w_th     = w_idle ? bus.th        : r_th;
   assign w_tf     = w_idle ? bus.tf        : r_tf;
   assign w_tl     = w_idle ? bus.tl        : r_tl;

   // Period phases are searched cyclically from here; DELAY/IDLE always start at RISE.
   assign w_base = (w_idle || (r_state == S_DELAY)) ? 3'(S_RISE) : (3'(r_state) + 3'd1);

   // First non-zero period phase at or after w_base, wrapping LOW back to RISE.
   always_comb begin
      logic [1:0]       v_off;
      logic [2:0]       v_try;
      logic [CNT_W-1:0] v_dur;
      logic             v_found;
      w_pick     = S_IDLE;
      w_pick_dur = CNT_W'(1);
      v_found    = 1'b0;
      v_off      = '0;
      v_try      = '0;
      v_dur      = '0;
      for (int k = 0; k < 4; k++) begin
         v_off = 2'(w_base - 3'd2) + 2'(k);
         v_try = {1'b0, v_off} + 3'd2;
         case (v_try)
            3'd2:    v_dur = w_tr;
            3'd3:    v_dur = w_th;
            3'd4:    v_dur = w_tf;
            default: v_dur = w_tl;
         endcase
         if (!v_found && (v_dur != '0)) begin
            v_found    = 1'b1;
            w_pick     = state_t'(v_try);
            w_pick_dur = v_dur;
         end
      end
   end

   // Next state and remaining-cycle count; a phase ends when the count reaches 0.
   always_comb begin
      w_nxt     = r_state;
      w_nxt_cnt = r_cnt;
      if (w_idle) begin
         w_nxt_cnt = '0;
         if (w_accept) begin
            if (bus.td != '0) begin
               w_nxt     = S_DELAY;
               w_nxt_cnt = bus.td - CNT_W'(1);
            end else begin
               w_nxt     = w_pick;
               w_nxt_cnt = w_pick_dur - CNT_W'(1);
            end
         end
      end else if (r_cnt != '0) begin
         w_nxt_cnt = r_cnt - CNT_W'(1);
      end else if (r_tick && (r_stop || bus.stop)) begin
         w_nxt     = S_IDLE;
         w_nxt_cnt = '0;
      end else begin
         w_nxt     = w_pick;
         w_nxt_cnt = w_pick_dur - CNT_W'(1);
      end
   end

   // Period tick marks the last cycle of the last non-zero phase of the period.
   always_comb begin
      case (w_nxt)
         S_RISE:  w_last = (w_th == '0) && (w_tf == '0) && (w_tl == '0);
         S_HIGH:  w_last = (w_tf == '0) && (w_tl == '0);
         S_FALL:  w_last = (w_tl == '0);
         S_LOW:   w_last = 1'b1;
         default: w_last = 1'b0;
      endcase
      w_tick_nxt = w_last && (w_nxt_cnt == '0);
   end

   // Level for the next cycle: saturating ramps, amp in HIGH, zero elsewhere.
   always_comb begin
      w_lvl_up = {1'b0, r_level} + {1'b0, w_rise};
      case (w_nxt)
         S_RISE:  w_lvl_nxt = (w_lvl_up > {1'b0, w_amp}) ? w_amp : w_lvl_up[AMP_W-1:0];
         S_HIGH:  w_lvl_nxt = w_amp;
         S_FALL:  w_lvl_nxt = (r_level > w_fall) ? (r_level - w_fall) : '0;
         default: w_lvl_nxt = '0;
      endcase
   end

   // Sticky stop: armed by stop while running (or with the accepted start), cleared in IDLE.
   always_comb begin
      if (w_nxt == S_IDLE)                        w_stop_nxt = 1'b0;
      else if (bus.stop && (!w_idle || w_accept)) w_stop_nxt = 1'b1;
      else                                        w_stop_nxt = r_stop;
   end

   // State, counter, registered outputs and configuration latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_level <= '0;
         r_busy  <= 1'b0;
         r_tick  <= 1'b0;
         r_stop  <= 1'b0;
         r_amp   <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         r_tr    <= '0;
         r_th    <= '0;
         r_tf    <= '0;
         r_tl    <= '0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_nxt_cnt;
         r_level <= w_lvl_nxt;
         r_busy  <= (w_nxt != S_IDLE);
         r_tick  <= w_tick_nxt;
         r_stop  <= w_stop_nxt;
         if (w_accept) begin
            r_amp  <= bus.amp;
            r_rise <= bus.rise_step;
            r_fall <= bus.fall_step;
            r_tr   <= bus.tr;
            r_th   <= bus.th;
            r_tf   <= bus.tf;
            r_tl   <= bus.tl;
         end
      end
   end

   assign bus.level       = r_level;
   assign bus.busy        = r_busy;
   assign bus.phase       = r_state;
   assign bus.period_tick = r_tick;

endmodule

// File: tb/tb_rect_wave_gen.sv
// Directed bench for rect_wave_gen with a period-table reference model.
module tb_rect_wave_gen;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   rect_wave_if #(.AMP_W(12), .CNT_W(16)) bus_if ();

   rect_wave_gen #(.AMP_W(12), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Reference model: one period is a table of phase codes, walked by index.
   int m_pat[$];
   int m_dly, m_idx, m_phase, m_level, m_amp, m_rs, m_fs;
   bit m_busy, m_stop, m_tick;

   task automatic model_reset();
      m_busy = 0; m_stop = 0; m_tick = 0; m_phase = 0; m_level = 0;
      m_dly = 0; m_idx = -1;
   endtask

   task automatic model_advance();
      if (m_dly > 0) begin
         m_dly--; m_phase = 1; m_level = 0; m_tick = 0;
      end else begin
         m_idx   = (m_idx + 1) % m_pat.size();
         m_phase = m_pat[m_idx];
         case (m_phase)
            2: begin m_level = m_level + m_rs; if (m_level > m_amp) m_level = m_amp; end
            3: m_level = m_amp;
            4: m_level = (m_level > m_fs) ? m_level - m_fs : 0;
            default: m_level = 0;
         endcase
         m_tick = (m_idx == m_pat.size() - 1);
      end
   endtask

   task automatic model_step();
      int sum;
      if (!rst_n) return;
      if (!m_busy) begin
         sum = int'(bus_if.tr) + int'(bus_if.th) + int'(bus_if.tf) + int'(bus_if.tl);
         if (bus_if.start && sum != 0) begin
            m_amp = int'(bus_if.amp); m_rs = int'(bus_if.rise_step); m_fs = int'(bus_if.fall_step);
            m_pat.delete();
            repeat (int'(bus_if.tr)) m_pat.push_back(2);
            repeat (int'(bus_if.th)) m_pat.push_back(3);
            repeat (int'(bus_if.tf)) m_pat.push_back(4);
            repeat (int'(bus_if.tl)) m_pat.push_back(5);
            m_dly = int'(bus_if.td); m_idx = -1; m_busy = 1; m_stop = bus_if.stop;
            model_advance();
         end
      end else begin
         if (bus_if.stop) m_stop = 1;
         if (m_dly == 0 && m_idx == m_pat.size() - 1 && m_stop) model_reset();
         else model_advance();
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: model steps on the edge, DUT compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("m_level", 32'(bus_if.level), 32'(m_level));
      chk("m_phase", 32'(bus_if.phase), 32'(m_phase));
      chk("m_busy",  32'(bus_if.busy),  32'(m_busy));
      chk("m_tick",  32'(bus_if.period_tick), 32'(m_tick));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic cfg(input int td_, input int tr_, input int th_, input int tf_, input int tl_,
                      input int amp_, input int rs_, input int fs_);
      bus_if.td = 16'(td_); bus_if.tr = 16'(tr_); bus_if.th = 16'(th_);
      bus_if.tf = 16'(tf_); bus_if.tl = 16'(tl_);
      bus_if.amp = 12'(amp_); bus_if.rise_step = 12'(rs_); bus_if.fall_step = 12'(fs_);
   endtask

   task automatic start_pulse(input bit with_stop);
      bus_if.start = 1'b1; bus_if.stop = with_stop;
      cycle();
      bus_if.start = 1'b0; bus_if.stop = 1'b0;
   endtask

   task automatic stop_and_wait(input int max);
      int n = 0;
      bus_if.stop = 1'b1;
      cycle();
      bus_if.stop = 1'b0;
      while (bus_if.busy && n < max) begin cycle(); n++; end
      chk("idle_timeout", 32'(bus_if.busy), 32'd0);
   endtask

   int exp35[16];
   int exp_carry[7];

   initial begin
      exp35     = '{0, 0, 30, 60, 90, 100, 100, 100, 100, 70, 40, 10, 0, 0, 0, 0};
      exp_carry = '{40, 80, 100, 100, 70, 40, 80};
      bus_if.start = 1'b0; bus_if.stop = 1'b0;
      cfg(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_level", 32'(bus_if.level), 32'd0);
      chk("rst_phase", 32'(bus_if.phase), 32'd0);
      chk("rst_busy",  32'(bus_if.busy),  32'd0);
      chk("rst_tick",  32'(bus_if.period_tick), 32'd0);
      run(2);
      rst_n = 1'b1;
      run(1);

      // Basic period with delay, then graceful stop during HIGH of period 2.
      cfg(2, 4, 3, 4, 3, 100, 30, 30);
      start_pulse(0);
      for (int i = 0; i < 16; i++) begin
         chk("basic_level", 32'(bus_if.level), 32'(exp35[i]));
         chk("basic_tick", 32'(bus_if.period_tick), (i == 15) ? 32'd1 : 32'd0);
         cycle();
      end
      chk("p2_phase", 32'(bus_if.phase), 32'd2);
      chk("p2_level", 32'(bus_if.level), 32'd30);
      run(5);
      chk("p2_high", 32'(bus_if.phase), 32'd3);
      bus_if.stop = 1'b1;
      cycle();
      bus_if.stop = 1'b0;
      run(7);
      chk("stop_tick", 32'(bus_if.period_tick), 32'd1);
      cycle();
      chk("stop_phase", 32'(bus_if.phase), 32'd0);
      chk("stop_busy",  32'(bus_if.busy),  32'd0);

      // Restart, then asynchronous reset mid-RISE.
      start_pulse(0);
      chk("restart_busy", 32'(bus_if.busy), 32'd1);
      run(3);
      chk("pre_rst_level", 32'(bus_if.level), 32'd60);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_level", 32'(bus_if.level), 32'd0);
      chk("arst_phase", 32'(bus_if.phase), 32'd0);
      chk("arst_busy",  32'(bus_if.busy),  32'd0);
      run(1);

      // Start on the first edge after reset release; reconfigure and restart while busy.
      rst_n = 1'b1;
      start_pulse(0);
      chk("first_edge_busy", 32'(bus_if.busy), 32'd1);
      cfg(0, 1, 1, 1, 1, 50, 7, 7);
      bus_if.start = 1'b1;
      cycle();
      bus_if.start = 1'b0;
      run(1);
      chk("ign_lvl2", 32'(bus_if.level), 32'd30);
      run(1);
      chk("ign_lvl3", 32'(bus_if.level), 32'd60);
      run(2);
      chk("ign_lvl5", 32'(bus_if.level), 32'd100);
      stop_and_wait(40);

      // Zero-length ramps: direct steps, no RISE/FALL.
      cfg(0, 0, 5, 0, 5, 4095, 1, 1);
      start_pulse(0);
      for (int i = 0; i < 25; i++) begin
         chk("no_ramp", 32'(bus_if.phase == 3'd2 || bus_if.phase == 3'd4), 32'd0);
         if (i == 0 || i == 10) chk("zr_high", 32'(bus_if.level), 32'd4095);
         if (i == 5) chk("zr_low", 32'(bus_if.level), 32'd0);
         if (i == 9) chk("zr_tick", 32'(bus_if.period_tick), 32'd1);
         cycle();
      end
      stop_and_wait(30);

      // Degenerate start is ignored.
      cfg(3, 0, 0, 0, 0, 100, 10, 10);
      bus_if.start = 1'b1;
      cycle();
      bus_if.start = 1'b0;
      run(3);
      chk("degen_busy",  32'(bus_if.busy),  32'd0);
      chk("degen_level", 32'(bus_if.level), 32'd0);

      // Stop in IDLE ignored; saturating rise.
      bus_if.stop = 1'b1;
      cycle();
      bus_if.stop = 1'b0;
      cfg(0, 3, 1, 1, 1, 4095, 4000, 4095);
      start_pulse(0);
      chk("sat0", 32'(bus_if.level), 32'd4000);
      run(1);
      chk("sat1", 32'(bus_if.level), 32'd4095);
      run(1);
      chk("sat2", 32'(bus_if.level), 32'd4095);
      run(4);
      chk("idle_stop_ign", 32'(bus_if.busy), 32'd1);
      chk("sat_p2", 32'(bus_if.level), 32'd4000);
      stop_and_wait(20);

      // Start and stop together: exactly one period.
      cfg(0, 4, 3, 4, 3, 100, 30, 30);
      start_pulse(1);
      run(13);
      chk("one_tick", 32'(bus_if.period_tick), 32'd1);
      cycle();
      chk("one_busy", 32'(bus_if.busy), 32'd0);

      // LOW skipped: FALL wraps straight into RISE, ramping from the fall level.
      cfg(0, 2, 2, 2, 0, 100, 40, 30);
      start_pulse(0);
      for (int i = 0; i < 7; i++) begin
         chk("carry_level", 32'(bus_if.level), 32'(exp_carry[i]));
         if (i == 5) chk("carry_tick", 32'(bus_if.period_tick), 32'd1);
         cycle();
      end
      stop_and_wait(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
